fwd_hazard_unit: RTL and testbench
==================================

FWD_HAZARD_UNIT -- requirements
Module: fwd_hazard_unit

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; all state SHALL be on the rising edge of clk.
REQ-002 Parameters SHALL be:
- MUL_CYCLES, 4, HI/LO busy cycles after a multiply issues.
- DIV_CYCLES, 32, HI/LO busy cycles after a divide issues.
REQ-003 Ports SHALL be, as name, direction, width, meaning:
- clk  in  1  clock
- rst_n  in  1  async active-low reset
- id_valid  in  1  ID holds a real instruction
- id_rs, id_rt  in  5 each  ID source registers
- id_use_rs, id_use_rt  in  1 each  source actually read
- id_wr  in  1  ID instruction writes the GPR
- id_dst  in  5  ID destination register
- id_load  in  1  ID instruction is a load
- id_md  in  1  ID instruction is a mult/div
- id_md_div  in  1  mult/div is a divide
- id_rhl  in  1  ID instruction reads HI/LO
- hold  in  1  external freeze, e.g. cache miss
- flush  in  1  exception flush
- stall  out  1  hold ID and insert an EX bubble
- ex_rs_sel, ex_rt_sel  out  2 each  EX operand forward select: 00 GPR, 01 MEM1, 10 MEM2, 11 WB
- md_busy  out  1  HI/LO result pending

Function
REQ-004 The block SHALL keep one record per stage for EX, MEM1, MEM2 and WB; each record SHALL hold valid, wr, dst and load; the EX record SHALL also hold rs, rt, use_rs and use_rt.
REQ-005 A producer SHALL match a register r when its valid=1, its wr=1, its dst!=0 and its dst==r; register 0 SHALL never match.
REQ-006 When hold=0 and flush=0, records SHALL advance every cycle: WB<=MEM2, MEM2<=MEM1, MEM1<=EX, EX<=ID record if (id_valid & !stall), else a bubble (valid=0).
REQ-007 When hold=1 and flush=0, all records SHALL keep their values.
REQ-008 When flush=1, the EX and MEM1 records SHALL become bubbles next cycle regardless of hold; MEM2 and WB SHALL advance if hold=0 and keep their values if hold=1.
REQ-009 ex_rs_sel SHALL be combinational from the current records and SHALL use the youngest match among MEM1 (01), MEM2 (10) and WB (11); with no match or use_rs=0 it SHALL be 00.
REQ-010 ex_rt_sel SHALL be computed the same way from rt and use_rt.
REQ-011 stall SHALL be combinational and SHALL assert only when id_valid=1 and at least one of the following holds:
- a used ID source's youngest match is a load in EX or in MEM1;
- (id_md | id_rhl) & md_busy.
REQ-012 An ALU producer SHALL never cause a stall; a load SHALL be forwardable only from WB, so a load immediately followed by a use SHALL produce 2 stall cycles, and with one independent instruction in between it SHALL produce 1 stall cycle.
REQ-013 A 6-bit counter md_cnt SHALL load MUL_CYCLES, or DIV_CYCLES when id_md_div=1, on a cycle where id_md & id_valid & !stall & !hold & !flush.
REQ-014 Otherwise md_cnt SHALL decrement by 1 every cycle while nonzero, independent of hold and flush, and SHALL saturate at 0.
REQ-015 md_busy SHALL equal (md_cnt != 0).
REQ-016 hold SHALL NOT mask stall; stall SHALL be evaluated purely from the current state.

Reset
REQ-017 While rst_n=0, all records SHALL be invalid and md_cnt SHALL be 0, so that stall=0, ex_rs_sel=ex_rt_sel=00 and md_busy=0 immediately, without waiting for a clock edge.
REQ-018 A reset asserted mid-operation, including during a divide countdown, SHALL discard all state; the first cycle after release SHALL behave as after power-up.

Verification
REQ-019 The bench SHALL cover:
- ALU chain: ADD wr $5, then SUB reading $5 → no stall; ex_rs_sel=01 in SUB's EX cycle. With one gap instruction → 10; with two gaps → 11; with three gaps → 00.
- Load-use: LW $8, then ADD reading rt=$8 → stall=1 for 2 cycles, then ex_rt_sel=11. With one gap instruction → 1 stall cycle.
- Youngest wins and $0: ADD $3 in WB and ADD $3 in MEM1 → ex_rs_sel=01. A producer with dst=$0 → ex_rs_sel=00.
- Divide: DIV issued at cycle t → md_busy=1 for cycles t+1..t+32. An MFLO in ID during that window → stall, released at t+33. With MUL → t+1..t+4.
- Flush/hold: LW in EX, flush=1 together with hold=1 → next cycle EX and MEM1 invalid, MEM2 and WB unchanged, and no load-use stall remains.
- Reset mid-divide: rst_n low at md_cnt=17 → md_busy=0 and stall=0 immediately.

Source files
------------

// File: rtl/fwd_hazard_unit_if.sv
// ID-stage instruction fields, pipeline control and hazard/forwarding results
// exchanged between the pipeline (master) and the hazard unit (slave).
interface fwd_hazard_unit_if;
  logic       id_valid;
  logic [4:0] id_rs;
  logic [4:0] id_rt;
  logic       id_use_rs;
  logic       id_use_rt;
  logic       id_wr;
  logic [4:0] id_dst;
  logic       id_load;
  logic       id_md;
  logic       id_md_div;
  logic       id_rhl;
  logic       hold;
  logic       flush;
  logic       stall;
  logic [1:0] ex_rs_sel;
  logic [1:0] ex_rt_sel;
  logic       md_busy;

  modport master (
    output id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_wr, id_dst,
           id_load, id_md, id_md_div, id_rhl, hold, flush,
    input  stall, ex_rs_sel, ex_rt_sel, md_busy
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_wr, id_dst,
           id_load, id_md, id_md_div, id_rhl, hold, flush,
    output stall, ex_rs_sel, ex_rt_sel, md_busy
  );
endinterface

// File: rtl/fwd_hazard_unit.sv
// Forwarding-select and load-use / HI-LO interlock unit for a pipeline with
// EX, MEM1, MEM2 and WB stages; loads are only forwardable from WB.
module fwd_hazard_unit #(
  parameter int unsigned MUL_CYCLES = 4,
  parameter int unsigned DIV_CYCLES = 32
) (
  input logic              clk,
  input logic              rst_n,
  fwd_hazard_unit_if.slave hz
);

  typedef struct packed {
    logic       valid;
    logic       wr;
    logic [4:0] dst;
    logic       load;
  } rec_t;

  typedef struct packed {
    rec_t       p;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       use_rs;
    logic       use_rt;
  } ex_rec_t;

  ex_rec_t    ex_q, ex_d;
  rec_t       mem1_q, mem1_d;
  rec_t       mem2_q, mem2_d;
  rec_t       wb_q, wb_d;
  logic [5:0] md_cnt_q, md_cnt_d;
  logic       stall_s;
  logic       md_busy_s;
  logic       md_issue_s;

  function automatic logic produces(input rec_t p, input logic [4:0] r);
    return p.valid & p.wr & (p.dst != 5'd0) & (p.dst == r);
  endfunction

  function automatic logic [1:0] fwd_sel(input logic use_r, input logic [4:0] r,
                                         input rec_t m1, input rec_t m2, input rec_t wb);
    logic [1:0] sel;
    if (!use_r)               sel = 2'b00;
    else if (produces(m1, r)) sel = 2'b01;
    else if (produces(m2, r)) sel = 2'b10;
    else if (produces(wb, r)) sel = 2'b11;
    else                      sel = 2'b00;
    return sel;
  endfunction

  // A younger ALU write of the same register shadows an older load.
  function automatic logic load_wait(input logic use_r, input logic [4:0] r,
                                     input rec_t ex, input rec_t m1);
    logic w;
    if (!use_r)               w = 1'b0;
    else if (produces(ex, r)) w = ex.load;
    else if (produces(m1, r)) w = m1.load;
    else                      w = 1'b0;
    return w;
  endfunction

  assign md_busy_s  = (md_cnt_q != 6'd0);
  assign stall_s    = hz.id_valid &
                      (load_wait(hz.id_use_rs, hz.id_rs, ex_q.p, mem1_q) |
                       load_wait(hz.id_use_rt, hz.id_rt, ex_q.p, mem1_q) |
                       ((hz.id_md | hz.id_rhl) & md_busy_s));
  assign md_issue_s = hz.id_md & hz.id_valid & ~stall_s & ~hz.hold & ~hz.flush;

  assign hz.stall     = stall_s;
  assign hz.md_busy   = md_busy_s;
  assign hz.ex_rs_sel = fwd_sel(ex_q.use_rs, ex_q.rs, mem1_q, mem2_q, wb_q);
  assign hz.ex_rt_sel = fwd_sel(ex_q.use_rt, ex_q.rt, mem1_q, mem2_q, wb_q);

  // Stage record advance, freeze and flush.
  always_comb begin
    ex_d   = ex_q;
    mem1_d = mem1_q;
    mem2_d = mem2_q;
    wb_d   = wb_q;
    if (hz.flush) begin
      ex_d   = '0;
      mem1_d = '0;
      if (!hz.hold) begin
        mem2_d = mem1_q;
        wb_d   = mem2_q;
      end else begin
        mem2_d = mem2_q;
        wb_d   = wb_q;
      end
    end else if (!hz.hold) begin
      wb_d   = mem2_q;
      mem2_d = mem1_q;
      mem1_d = ex_q.p;
      if (hz.id_valid && !stall_s) begin
        ex_d.p.valid = 1'b1;
        ex_d.p.wr    = hz.id_wr;
        ex_d.p.dst   = hz.id_dst;
        ex_d.p.load  = hz.id_load;
        ex_d.rs      = hz.id_rs;
        ex_d.rt      = hz.id_rt;
        ex_d.use_rs  = hz.id_use_rs;
        ex_d.use_rt  = hz.id_use_rt;
      end else begin
        ex_d = '0;
      end
    end else begin
      ex_d = ex_q;
    end
  end

  // HI/LO busy countdown; keeps running through hold and flush.
  always_comb begin
    md_cnt_d = md_cnt_q;
    if (md_issue_s) begin
      md_cnt_d = hz.id_md_div ? 6'(DIV_CYCLES) : 6'(MUL_CYCLES);
    end else if (md_cnt_q != 6'd0) begin
      md_cnt_d = md_cnt_q - 6'd1;
    end else begin
      md_cnt_d = 6'd0;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q     <= '0;
      mem1_q   <= '0;
      mem2_q   <= '0;
      wb_q     <= '0;
      md_cnt_q <= 6'd0;
    end else begin
      ex_q     <= ex_d;
      mem1_q   <= mem1_d;
      mem2_q   <= mem2_d;
      wb_q     <= wb_d;
      md_cnt_q <= md_cnt_d;
    end
  end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed scenarios plus a randomized stream for fwd_hazard_unit, checked
// against a pipeline-array / timestamp model of forwarding and interlocks.
module tb_fwd_hazard_unit;
  localparam int MULC = 4;
  localparam int DIVC = 32;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fwd_hazard_unit_if hz();

  fwd_hazard_unit #(.MUL_CYCLES(MULC), .DIV_CYCLES(DIVC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .hz    (hz)
  );

  typedef struct packed {
    logic       valid;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       use_rs;
    logic       use_rt;
    logic       wr;
    logic [4:0] dst;
    logic       load;
    logic       md;
    logic       md_div;
    logic       rhl;
  } instr_t;

  typedef struct packed {
    logic       valid;
    logic       wr;
    logic       load;
    logic [4:0] dst;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       use_rs;
    logic       use_rt;
  } mrec_t;

  // Model: pipe[0]=EX .. pipe[3]=WB; HI/LO busy through cycle md_end.
  mrec_t pipe [4];
  int    cyc    = 0;
  int    md_end = -1;
  int    checks = 0;
  int    errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic instr_t alu(input int d, input int s, input int t);
    instr_t i = '0;
    i.valid = 1'b1; i.wr = 1'b1; i.dst = 5'(d);
    i.rs = 5'(s); i.rt = 5'(t); i.use_rs = 1'b1; i.use_rt = 1'b1;
    return i;
  endfunction

  function automatic instr_t lw(input int d, input int base);
    instr_t i = '0;
    i.valid = 1'b1; i.wr = 1'b1; i.load = 1'b1; i.dst = 5'(d);
    i.rs = 5'(base); i.use_rs = 1'b1;
    return i;
  endfunction

  function automatic instr_t muldiv(input bit div);
    instr_t i = '0;
    i.valid = 1'b1; i.md = 1'b1; i.md_div = div;
    i.rs = 5'd1; i.rt = 5'd2; i.use_rs = 1'b1; i.use_rt = 1'b1;
    return i;
  endfunction

  function automatic instr_t mflo(input int d);
    instr_t i = '0;
    i.valid = 1'b1; i.rhl = 1'b1; i.wr = 1'b1; i.dst = 5'(d);
    return i;
  endfunction

  function automatic bit prod(input mrec_t p, input logic [4:0] r);
    return p.valid && p.wr && (p.dst != 5'd0) && (p.dst == r);
  endfunction

  function automatic logic [1:0] m_sel(input logic u, input logic [4:0] r);
    if (u) for (int k = 1; k < 4; k++) if (prod(pipe[k], r)) return 2'(k);
    return 2'b00;
  endfunction

  // Wait while the nearest older writer of r is a load still before MEM2.
  function automatic bit m_loadwait(input logic u, input logic [4:0] r);
    if (u) for (int k = 0; k < 4; k++) if (prod(pipe[k], r)) return (k < 2) && pipe[k].load;
    return 1'b0;
  endfunction

  function automatic bit m_busy();
    return cyc <= md_end;
  endfunction

  function automatic bit m_stall();
    return hz.id_valid && (m_loadwait(hz.id_use_rs, hz.id_rs) ||
                           m_loadwait(hz.id_use_rt, hz.id_rt) ||
                           ((hz.id_md || hz.id_rhl) && m_busy()));
  endfunction

  task automatic drive(input instr_t i);
    hz.id_valid = i.valid;  hz.id_rs = i.rs;         hz.id_rt = i.rt;
    hz.id_use_rs = i.use_rs; hz.id_use_rt = i.use_rt; hz.id_wr = i.wr;
    hz.id_dst = i.dst;      hz.id_load = i.load;     hz.id_md = i.md;
    hz.id_md_div = i.md_div; hz.id_rhl = i.rhl;
  endtask

  task automatic step(output logic dut_stall, output bit accepted);
    mrec_t nx [4];
    bit    ms;
    #1;
    ms = m_stall();
    chk("stall",     {31'b0, hz.stall},     {31'b0, ms});
    chk("ex_rs_sel", {30'b0, hz.ex_rs_sel}, {30'b0, m_sel(pipe[0].use_rs, pipe[0].rs)});
    chk("ex_rt_sel", {30'b0, hz.ex_rt_sel}, {30'b0, m_sel(pipe[0].use_rt, pipe[0].rt)});
    chk("md_busy",   {31'b0, hz.md_busy},   {31'b0, m_busy()});
    dut_stall = hz.stall;
    accepted  = hz.id_valid && !ms && !hz.hold && !hz.flush;
    nx = pipe;
    if (hz.flush) begin
      nx[0] = '0;
      nx[1] = '0;
      if (!hz.hold) begin
        nx[2] = pipe[1];
        nx[3] = pipe[2];
      end
    end else if (!hz.hold) begin
      nx[3] = pipe[2];
      nx[2] = pipe[1];
      nx[1] = pipe[0];
      nx[1].rs = '0; nx[1].rt = '0; nx[1].use_rs = 1'b0; nx[1].use_rt = 1'b0;
      if (accepted)
        nx[0] = '{valid: 1'b1, wr: hz.id_wr, load: hz.id_load, dst: hz.id_dst,
                  rs: hz.id_rs, rt: hz.id_rt, use_rs: hz.id_use_rs, use_rt: hz.id_use_rt};
      else
        nx[0] = '0;
    end
    if (accepted && hz.id_md) md_end = cyc + (hz.id_md_div ? DIVC : MULC);
    @(posedge clk);
    pipe = nx;
    cyc++;
    @(negedge clk);
  endtask

  task automatic issue(input instr_t i, output int nst);
    logic ds;
    bit   acc;
    nst = 0;
    acc = 1'b0;
    drive(i);
    for (int n = 0; n < 64 && !acc; n++) begin
      step(ds, acc);
      if (ds === 1'b1) nst++;
    end
    chk("issue_accepted", {31'b0, acc}, 32'd1);
    drive('0);
  endtask

  task automatic idle_steps(input int n);
    logic ds;
    bit   acc;
    drive('0);
    repeat (n) step(ds, acc);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_stall",   {31'b0, hz.stall},     32'd0);
    chk("rst_md_busy", {31'b0, hz.md_busy},   32'd0);
    chk("rst_rs_sel",  {30'b0, hz.ex_rs_sel}, 32'd0);
    chk("rst_rt_sel",  {30'b0, hz.ex_rt_sel}, 32'd0);
    for (int k = 0; k < 4; k++) pipe[k] = '0;
    md_end = -1;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int          n;
    logic        ds;
    bit          acc;
    instr_t      ri;
    logic [1:0]  gap_sel [4];

    gap_sel[0] = 2'b01; gap_sel[1] = 2'b10; gap_sel[2] = 2'b11; gap_sel[3] = 2'b00;
    rst_n = 1'b0;
    hz.hold = 1'b0;
    hz.flush = 1'b0;
    drive('0);
    do_reset();

    // ALU chain with 0..3 independent instructions between producer and consumer.
    for (int g = 0; g < 4; g++) begin
      idle_steps(4);
      issue(alu(5, 1, 2), n);
      for (int k = 0; k < g; k++) issue(alu(20, 21, 22), n);
      issue(alu(6, 5, 7), n);
      chk("alu_no_stall", n, 32'd0);
      #1;
      chk("alu_gap_rs_sel", {30'b0, hz.ex_rs_sel}, {30'b0, gap_sel[g]});
    end

    // Load-use, back to back and with one gap.
    idle_steps(4);
    issue(lw(8, 1), n);
    issue(alu(9, 3, 8), n);
    chk("lu_stall_cycles", n, 32'd2);
    #1;
    chk("lu_rt_sel_wb", {30'b0, hz.ex_rt_sel}, 32'd3);
    idle_steps(4);
    issue(lw(8, 1), n);
    issue(alu(20, 21, 22), n);
    issue(alu(9, 3, 8), n);
    chk("lu_gap_stall_cycles", n, 32'd1);
    #1;
    chk("lu_gap_rt_sel", {30'b0, hz.ex_rt_sel}, 32'd3);

    // Youngest producer wins; $0 never forwards.
    idle_steps(4);
    issue(alu(3, 1, 2), n);
    issue(alu(20, 21, 22), n);
    issue(alu(3, 4, 4), n);
    issue(alu(9, 3, 7), n);
    #1;
    chk("youngest_rs_sel", {30'b0, hz.ex_rs_sel}, 32'd1);
    idle_steps(4);
    issue(alu(0, 1, 2), n);
    issue(alu(9, 0, 7), n);
    #1;
    chk("reg0_rs_sel", {30'b0, hz.ex_rs_sel}, 32'd0);

    // HI/LO interlock after divide and multiply.
    idle_steps(4);
    issue(muldiv(1'b1), n);
    issue(mflo(9), n);
    chk("div_mflo_stall_cycles", n, 32'd32);
    idle_steps(4);
    issue(muldiv(1'b0), n);
    issue(mflo(9), n);
    chk("mul_mflo_stall_cycles", n, 32'd4);

    // Flush together with hold while a load sits in EX.
    idle_steps(6);
    issue(alu(10, 1, 2), n);
    issue(alu(11, 1, 2), n);
    issue(alu(12, 1, 2), n);
    issue(lw(8, 1), n);
    drive(alu(9, 11, 8));
    hz.flush = 1'b1;
    hz.hold  = 1'b1;
    step(ds, acc);
    chk("fh_pre_stall", {31'b0, ds}, 32'd1);
    hz.flush = 1'b0;
    hz.hold  = 1'b0;
    #1;
    chk("fh_no_loaduse_stall", {31'b0, hz.stall}, 32'd0);
    issue(alu(9, 11, 8), n);
    #1;
    chk("fh_rs_sel_kept_mem2", {30'b0, hz.ex_rs_sel}, 32'd3);
    chk("fh_rt_sel_flushed",   {30'b0, hz.ex_rt_sel}, 32'd0);

    // Reset in the middle of a divide countdown.
    idle_steps(4);
    issue(muldiv(1'b1), n);
    drive(mflo(9));
    repeat (15) step(ds, acc);
    #1;
    chk("pre_rst_stall", {31'b0, hz.stall}, 32'd1);
    do_reset();
    issue(mflo(9), n);
    chk("post_rst_mflo_stall_cycles", n, 32'd0);

    // Randomized stream over a small register set.
    for (int i = 0; i < 600; i++) begin
      if (i == 300) begin
        drive(mflo(2));
        do_reset();
      end
      ri        = '0;
      ri.valid  = ($urandom_range(0, 7) != 0);
      ri.rs     = 5'($urandom_range(0, 3));
      ri.rt     = 5'($urandom_range(0, 3));
      ri.use_rs = 1'($urandom_range(0, 1));
      ri.use_rt = 1'($urandom_range(0, 1));
      ri.wr     = ($urandom_range(0, 4) != 0);
      ri.dst    = 5'($urandom_range(0, 3));
      ri.load   = ($urandom_range(0, 3) == 0);
      ri.md     = ($urandom_range(0, 24) == 0);
      ri.md_div = 1'($urandom_range(0, 1));
      ri.rhl    = ($urandom_range(0, 15) == 0);
      drive(ri);
      hz.hold  = ($urandom_range(0, 9) == 0);
      hz.flush = ($urandom_range(0, 19) == 0);
      step(ds, acc);
    end
    hz.hold  = 1'b0;
    hz.flush = 1'b0;
    idle_steps(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
